// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the SRAM-to-handshake bridge.
// Optional MIPS kseg0/kseg1 address folding is enabled with BRIDGE_KSEG_MAP_EN.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } chan_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] KSEG_LO        = 32'h8000_0000;
    localparam logic [31:0] KSEG_HI        = 32'hBFFF_FFFF;
    localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

    // Irregular strobe patterns go out as a word access with the raw strobes.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        case (wen)
            4'b0011, 4'b1100:                   return SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_BYTE;
            default:                            return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/sram_bridge_chan.sv
// One bridge channel: latches a core access, runs it on the handshake bus,
// and holds the result while the pipeline is frozen. Honors BRIDGE_KSEG_MAP_EN.
module sram_bridge_chan
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [BE_W-1:0]   cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_hold,
    input  logic              cpu_flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [BE_W-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    chan_state_e       state, state_d;
    logic [ADDR_W-1:0] addr_q, phys_addr;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [BE_W-1:0]   wen_q;
    logic              drop_q, drop_eff, start, capture;

    assign start    = cpu_en & ~cpu_flush;
    assign drop_eff = drop_q | cpu_flush;

    always_comb begin
        state_d = state;
        capture = 1'b0;
        case (state)
            IDLE: if (start) state_d = REQ;
            REQ: begin
                if (bus_addr_ok && bus_data_ok) begin
                    state_d = drop_eff ? IDLE : DONE;
                    capture = ~drop_eff;
                end else if (bus_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    state_d = drop_eff ? IDLE : DONE;
                    capture = ~drop_eff;
                end
            end
            DONE: if (cpu_flush || !cpu_hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= '0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wen_q   <= cpu_wen;
            end
            if (capture) rdata_q <= bus_rdata;
            // A flushed access still finishes on the bus; only its result is dropped.
            if (state_d == IDLE)
                drop_q <= 1'b0;
            else if ((state == REQ || state == WAIT) && cpu_flush)
                drop_q <= 1'b1;
        end
    end

`ifdef BRIDGE_KSEG_MAP_EN
    assign phys_addr = (addr_q >= ADDR_W'(KSEG_LO) && addr_q <= ADDR_W'(KSEG_HI))
                     ? (addr_q & ADDR_W'(KSEG_PHYS_MASK)) : addr_q;
`else
    assign phys_addr = addr_q;
`endif

    // Payload is zeroed outside REQ so the bus sees a quiet interface when idle.
    assign bus_req   = (state == REQ);
    assign bus_wr    = bus_req & (|wen_q);
    assign bus_size  = bus_req ? wen_to_size(4'(wen_q)) : 2'b00;
    assign bus_wstrb = bus_req ? wen_q : '0;
    assign bus_addr  = bus_req ? phys_addr : '0;
    assign bus_wdata = bus_req ? wdata_q : '0;

    assign cpu_rdata = rdata_q;
    assign cpu_stall = (state == IDLE && start) ||
                       ((state == REQ || state == WAIT) && !drop_q);

endmodule

// File: rtl/sram_like_bridge.sv
// Multi-channel bridge from single-cycle SRAM ports to an addr_ok/data_ok bus.
// Channels are independent; BRIDGE_KSEG_MAP_EN enables kseg address folding.
module sram_like_bridge
    import sram_bridge_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        cpu_en,
    input  logic [NUM_CH*BE_W-1:0]   cpu_wen,
    input  logic [NUM_CH*ADDR_W-1:0] cpu_addr,
    input  logic [NUM_CH*DATA_W-1:0] cpu_wdata,
    input  logic [NUM_CH-1:0]        cpu_hold,
    input  logic [NUM_CH-1:0]        cpu_flush,
    output logic [NUM_CH*DATA_W-1:0] cpu_rdata,
    output logic [NUM_CH-1:0]        cpu_stall,
    output logic [NUM_CH-1:0]        bus_req,
    output logic [NUM_CH-1:0]        bus_wr,
    output logic [NUM_CH*2-1:0]      bus_size,
    output logic [NUM_CH*BE_W-1:0]   bus_wstrb,
    output logic [NUM_CH*ADDR_W-1:0] bus_addr,
    output logic [NUM_CH*DATA_W-1:0] bus_wdata,
    input  logic [NUM_CH-1:0]        bus_addr_ok,
    input  logic [NUM_CH-1:0]        bus_data_ok,
    input  logic [NUM_CH*DATA_W-1:0] bus_rdata
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sram_bridge_chan #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cpu_en      (cpu_en[c]),
            .cpu_wen     (cpu_wen[c*BE_W +: BE_W]),
            .cpu_addr    (cpu_addr[c*ADDR_W +: ADDR_W]),
            .cpu_wdata   (cpu_wdata[c*DATA_W +: DATA_W]),
            .cpu_hold    (cpu_hold[c]),
            .cpu_flush   (cpu_flush[c]),
            .cpu_rdata   (cpu_rdata[c*DATA_W +: DATA_W]),
            .cpu_stall   (cpu_stall[c]),
            .bus_req     (bus_req[c]),
            .bus_wr      (bus_wr[c]),
            .bus_size    (bus_size[c*2 +: 2]),
            .bus_wstrb   (bus_wstrb[c*BE_W +: BE_W]),
            .bus_addr    (bus_addr[c*ADDR_W +: ADDR_W]),
            .bus_wdata   (bus_wdata[c*DATA_W +: DATA_W]),
            .bus_addr_ok (bus_addr_ok[c]),
            .bus_data_ok (bus_data_ok[c]),
            .bus_rdata   (bus_rdata[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: table of single accesses plus
// hand-written sequences for slave delay, hold, flush, reset and dual channel.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpu_en, cpu_hold, cpu_flush, bus_addr_ok, bus_data_ok;
    logic [7:0]  cpu_wen;
    logic [63:0] cpu_addr, cpu_wdata, bus_rdata;
    logic [63:0] cpu_rdata, bus_addr, bus_wdata;
    logic [1:0]  cpu_stall, bus_req, bus_wr;
    logic [3:0]  bus_size;
    logic [7:0]  bus_wstrb;

    int passed = 0;
    int total  = 0;

`ifdef BRIDGE_KSEG_MAP_EN
    localparam logic [31:0] EXP_KSEG = 32'h1FC0_0000;
`else
    localparam logic [31:0] EXP_KSEG = 32'hBFC0_0000;
`endif

    sram_like_bridge #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_hold(cpu_hold), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic        wr;
    } vec_t;

    vec_t vec[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        vec[0] = '{4'b0000, 32'h0000_1000, 32'h0000_0000, 32'h1234_5678, 2'd2, 4'b0000, 1'b0};
        vec[1] = '{4'b1111, 32'h0000_1004, 32'hA5A5_5A5A, 32'h0000_0011, 2'd2, 4'b1111, 1'b1};
        vec[2] = '{4'b0011, 32'h0000_1008, 32'h0000_BEEF, 32'h0000_0022, 2'd1, 4'b0011, 1'b1};
        vec[3] = '{4'b1100, 32'h0000_100A, 32'hBEEF_0000, 32'h0000_0033, 2'd1, 4'b1100, 1'b1};
        vec[4] = '{4'b0001, 32'h0000_100C, 32'h0000_0077, 32'h0000_0044, 2'd0, 4'b0001, 1'b1};
        vec[5] = '{4'b1000, 32'h0000_100F, 32'h8800_0000, 32'h0000_0055, 2'd0, 4'b1000, 1'b1};
        vec[6] = '{4'b0110, 32'h0000_1010, 32'h0012_3400, 32'h0000_0066, 2'd2, 4'b0110, 1'b1};
        vec[7] = '{4'b0111, 32'h0000_1014, 32'h00AB_CDEF, 32'h0000_0088, 2'd2, 4'b0111, 1'b1};

        rst = 1'b1;
        cpu_en = '0; cpu_hold = '0; cpu_flush = '0; bus_addr_ok = '0; bus_data_ok = '0;
        cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0; bus_rdata = '0;
        tick(); tick();
        chk("rst_stall", cpu_stall, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_busaddr", bus_addr, 0);
        chk("rst_size_wstrb", {bus_size, bus_wstrb, bus_wr}, 0);
        rst = 1'b0;
        tick();

        // Minimum-latency single accesses on channel 0
        for (int i = 0; i < 8; i++) begin
            cpu_en[0] = 1'b1; cpu_wen[3:0] = vec[i].wen;
            cpu_addr[31:0] = vec[i].addr; cpu_wdata[31:0] = vec[i].wdata;
            settle();
            chk($sformatf("v%0d_c0_stall", i), cpu_stall[0], 1);
            chk($sformatf("v%0d_c0_req", i), bus_req[0], 0);
            tick();
            bus_addr_ok[0] = 1'b1;
            settle();
            chk($sformatf("v%0d_c1_req", i), bus_req[0], 1);
            chk($sformatf("v%0d_size", i), bus_size[1:0], vec[i].size);
            chk($sformatf("v%0d_wstrb", i), bus_wstrb[3:0], vec[i].wstrb);
            chk($sformatf("v%0d_wr", i), bus_wr[0], vec[i].wr);
            chk($sformatf("v%0d_addr", i), bus_addr[31:0], vec[i].addr);
            chk($sformatf("v%0d_wdata", i), bus_wdata[31:0], vec[i].wdata);
            tick();
            bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = vec[i].rdata;
            settle();
            chk($sformatf("v%0d_c2_stall", i), cpu_stall[0], 1);
            chk($sformatf("v%0d_c2_req", i), bus_req[0], 0);
            tick();
            bus_data_ok[0] = 1'b0; cpu_en[0] = 1'b0;
            settle();
            chk($sformatf("v%0d_c3_stall", i), cpu_stall[0], 0);
            chk($sformatf("v%0d_rdata", i), cpu_rdata[31:0], vec[i].rdata);
            tick();
        end

        // Byte write with slow slave: addr_ok after 3 cycles, data_ok 3 cycles later
        cpu_en[0] = 1'b1; cpu_wen[3:0] = 4'b0100; cpu_addr[31:0] = 32'h0000_0102;
        cpu_wdata[31:0] = 32'h00AB_0000;
        settle(); tick();
        for (int k = 0; k < 4; k++) begin
            bus_addr_ok[0] = (k == 3);
            settle();
            chk($sformatf("slow_req%0d", k), bus_req[0], 1);
            chk($sformatf("slow_pay%0d", k), {bus_size[1:0], bus_wstrb[3:0], bus_addr[31:0]},
                {2'd0, 4'b0100, 32'h0000_0102});
            tick();
        end
        bus_addr_ok[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_data_ok[0] = (k == 2);
            settle();
            chk($sformatf("slow_wait_stall%0d", k), {bus_req[0], cpu_stall[0]}, 2'b01);
            tick();
        end
        bus_data_ok[0] = 1'b0; cpu_en[0] = 1'b0;
        settle();
        chk("slow_done_stall", cpu_stall[0], 0);
        tick();

        // Hold for 5 cycles after completion, then a new access
        cpu_en[0] = 1'b1; cpu_wen[3:0] = 4'b0000; cpu_addr[31:0] = 32'h0000_2000;
        settle(); tick();
        bus_addr_ok[0] = 1'b1; tick();
        bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'hCAFE_0001; tick();
        bus_data_ok[0] = 1'b0; bus_rdata[31:0] = 32'h0BAD_0BAD; cpu_hold[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("hold_st%0d", k), {cpu_stall[0], bus_req[0]}, 2'b00);
            chk($sformatf("hold_rdata%0d", k), cpu_rdata[31:0], 32'hCAFE_0001);
            tick();
        end
        cpu_hold[0] = 1'b0; cpu_addr[31:0] = 32'h0000_2004;
        settle(); tick();
        settle();
        chk("hold_new_stall", cpu_stall[0], 1);
        tick();
        bus_addr_ok[0] = 1'b1; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'hCAFE_0002;
        settle();
        chk("hold_new_req", {bus_req[0], bus_addr[31:0]}, {1'b1, 32'h0000_2004});
        tick();
        bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b0; cpu_en[0] = 1'b0;
        settle();
        chk("same_cycle_ok_rdata", {cpu_stall[0], cpu_rdata[31:0]}, {1'b0, 32'hCAFE_0002});
        tick();

        // Flush while waiting for data
        cpu_en[0] = 1'b1; cpu_addr[31:0] = 32'h0000_3000;
        settle(); tick();
        bus_addr_ok[0] = 1'b1; settle(); tick();
        bus_addr_ok[0] = 1'b0; cpu_flush[0] = 1'b1; settle(); tick();
        cpu_flush[0] = 1'b0; cpu_en[0] = 1'b0;
        settle();
        chk("flush_stall_drop", cpu_stall[0], 0);
        tick();
        bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'hDEAD_BEEF;
        settle();
        chk("flush_dataok_stall", cpu_stall[0], 0);
        tick();
        bus_data_ok[0] = 1'b0;
        settle();
        chk("flush_rdata_kept", cpu_rdata[31:0], 32'hCAFE_0002);
        cpu_en[0] = 1'b1; cpu_addr[31:0] = 32'h0000_3004;
        settle();
        chk("flush_back_idle", cpu_stall[0], 1);
        tick();
        settle();
        chk("flush_next_req", bus_req[0], 1);
        bus_addr_ok[0] = 1'b1; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'h5555_AAAA;
        tick();
        bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b0; cpu_en[0] = 1'b0;
        settle();
        chk("flush_next_rdata", cpu_rdata[31:0], 32'h5555_AAAA);
        tick();

        // Reset while requesting
        cpu_en[0] = 1'b1; cpu_addr[31:0] = 32'h0000_4000;
        settle(); tick();
        settle();
        chk("rstreq_req", bus_req[0], 1);
        rst = 1'b1; tick();
        rst = 1'b0; cpu_en[0] = 1'b0;
        settle();
        chk("rstreq_after", {bus_req[0], cpu_stall[0], cpu_rdata[31:0]}, 0);
        tick();

        // Both channels concurrently, with the kseg address on channel 0
        cpu_en = 2'b11; cpu_wen = '0;
        cpu_addr = {32'h0040_0000, 32'hBFC0_0000};
        settle();
        chk("dual_c0_stall", cpu_stall, 2'b11);
        tick();
        bus_addr_ok = 2'b01;
        settle();
        chk("dual_c1_req", bus_req, 2'b11);
        chk("kseg_addr", bus_addr[31:0], EXP_KSEG);
        chk("useg_addr", bus_addr[63:32], 32'h0040_0000);
        tick();
        bus_addr_ok = 2'b10; bus_data_ok = 2'b01; bus_rdata = {32'h1111_1111, 32'hA0A0_0000};
        settle();
        chk("dual_c2", {bus_req, cpu_stall}, {2'b10, 2'b11});
        tick();
        bus_addr_ok = 2'b00; bus_data_ok = 2'b10; bus_rdata = {32'h0B0B_1111, 32'hFFFF_FFFF};
        cpu_en = 2'b10;
        settle();
        chk("dual_c3_stall", cpu_stall, 2'b10);
        chk("dual_c3_rdata0", cpu_rdata[31:0], 32'hA0A0_0000);
        tick();
        bus_data_ok = 2'b00; cpu_en = 2'b00;
        settle();
        chk("dual_c4_stall", cpu_stall, 2'b00);
        chk("dual_c4_rdata", cpu_rdata, {32'h0B0B_1111, 32'hA0A0_0000});
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
